// File: rtl/crop_filter_unit.sv
// Streaming region-of-interest cropper: forwards the OUT_ROWS x OUT_COLS window at (Y_1, X_1).
// Define CROP_FILTER_UNIT_LAST_EN to add out_last, flagging the final cropped pixel of a frame.
module crop_filter_unit #(
  parameter int PIXEL_BIT_WIDTH = 16,
  parameter int IN_ROWS         = 100,
  parameter int IN_COLS         = 160,
  parameter int OUT_ROWS        = 48,
  parameter int OUT_COLS        = 48,
  parameter int Y_1             = 10,
  parameter int X_1             = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [PIXEL_BIT_WIDTH-1:0] pixel_out,
  output logic                       out_valid,
  input  logic                       out_ready
`ifdef CROP_FILTER_UNIT_LAST_EN
  ,
  output logic                       out_last
`endif
);

  localparam int ROW_W = (IN_ROWS > 1) ? $clog2(IN_ROWS) : 1;
  localparam int COL_W = (IN_COLS > 1) ? $clog2(IN_COLS) : 1;
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IN_ROWS - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IN_COLS - 1);
  localparam logic [ROW_W-1:0] ROW_ONE = ROW_W'(1);
  localparam logic [COL_W-1:0] COL_ONE = COL_W'(1);

  generate
    if (PIXEL_BIT_WIDTH < 1 || IN_ROWS < 1 || IN_COLS < 1 || OUT_ROWS < 1 ||
        OUT_COLS < 1 || Y_1 < 0 || X_1 < 0 ||
        Y_1 + OUT_ROWS > IN_ROWS || X_1 + OUT_COLS > IN_COLS) begin : g_bad_params
      $error("crop_filter_unit: crop window does not fit inside the input frame");
    end
  endgenerate

  logic [ROW_W-1:0]           row_p0;
  logic [COL_W-1:0]           col_p0;
  logic                       take_p0;
  logic                       in_win_p0;
  logic [PIXEL_BIT_WIDTH-1:0] pixel_p1;
  logic                       vld_p1;

  // Stage 0: position of the pixel presented this cycle and the window test
  assign in_ready  = ~vld_p1 | out_ready;
  assign take_p0   = in_valid & in_ready;
  assign in_win_p0 = (int'(row_p0) >= Y_1) && (int'(row_p0) < Y_1 + OUT_ROWS) &&
                     (int'(col_p0) >= X_1) && (int'(col_p0) < X_1 + OUT_COLS);

`ifdef CROP_FILTER_UNIT_LAST_EN
  logic last_p0;
  logic last_p1;
  assign last_p0  = (int'(row_p0) == Y_1 + OUT_ROWS - 1) && (int'(col_p0) == X_1 + OUT_COLS - 1);
  assign out_last = last_p1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_p0 <= '0;
      col_p0 <= '0;
    end else if (take_p0) begin
      if (col_p0 == COL_MAX) begin
        col_p0 <= '0;
        row_p0 <= (row_p0 == ROW_MAX) ? '0 : row_p0 + ROW_ONE;
      end else begin
        col_p0 <= col_p0 + COL_ONE;
      end
    end
  end

  // Stage 1: single output register; an in-window load wins over a plain drain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixel_p1 <= '0;
      vld_p1   <= 1'b0;
`ifdef CROP_FILTER_UNIT_LAST_EN
      last_p1  <= 1'b0;
`endif
    end else if (take_p0 && in_win_p0) begin
      pixel_p1 <= pixel_in;
      vld_p1   <= 1'b1;
`ifdef CROP_FILTER_UNIT_LAST_EN
      last_p1  <= last_p0;
`endif
    end else if (out_ready) begin
      vld_p1   <= 1'b0;
    end
  end

  assign pixel_out = pixel_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_crop_filter_unit.sv
// Bench for crop_filter_unit: four parameterisations share one stimulus bus, a queue scoreboard checks each.
module tb_crop_filter_unit;
  localparam int PW = 16;

  typedef struct {
    int in_rows; int in_cols; int out_rows; int out_cols; int y1; int x1;
  } cfg_t;

  typedef struct {
    string name; int sel; int pixels; int vpct; int rpct;
    int exp_count; int exp_first; int exp_last;
  } scen_t;

  typedef struct { int k; int v; } idx_t;

  cfg_t  cfg [4];
  scen_t tbl [5];
  idx_t  idx_tbl [5];

  logic          clk = 1'b0;
  logic          reset;
  logic [PW-1:0] pixel_in;
  logic          in_valid;
  logic          out_ready;
  logic          ir [4];
  logic          ov [4];
  logic [PW-1:0] po [4];
`ifdef CROP_FILTER_UNIT_LAST_EN
  logic          ol [4];
`endif

  logic [1:0]    sel;
  logic          dut_in_ready;
  logic          dut_out_valid;
  logic [PW-1:0] dut_pixel_out;
  logic          dut_out_last;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q [$];
  int out_log [$];
  int model_idx = 0;
  bit hold = 0;
  int hold_pix = 0;

  always #5 clk = ~clk;

  crop_filter_unit #(.PIXEL_BIT_WIDTH(PW)) u_dflt (
    .clk(clk), .reset(reset), .pixel_in(pixel_in), .in_valid(in_valid), .in_ready(ir[0]),
    .pixel_out(po[0]), .out_valid(ov[0]), .out_ready(out_ready)
`ifdef CROP_FILTER_UNIT_LAST_EN
    , .out_last(ol[0])
`endif
  );

  crop_filter_unit #(.PIXEL_BIT_WIDTH(PW), .IN_ROWS(8), .IN_COLS(12), .OUT_ROWS(3),
                     .OUT_COLS(5), .Y_1(2), .X_1(6)) u_small (
    .clk(clk), .reset(reset), .pixel_in(pixel_in), .in_valid(in_valid), .in_ready(ir[1]),
    .pixel_out(po[1]), .out_valid(ov[1]), .out_ready(out_ready)
`ifdef CROP_FILTER_UNIT_LAST_EN
    , .out_last(ol[1])
`endif
  );

  crop_filter_unit #(.PIXEL_BIT_WIDTH(PW), .IN_ROWS(4), .IN_COLS(4), .OUT_ROWS(4),
                     .OUT_COLS(4), .Y_1(0), .X_1(0)) u_full (
    .clk(clk), .reset(reset), .pixel_in(pixel_in), .in_valid(in_valid), .in_ready(ir[2]),
    .pixel_out(po[2]), .out_valid(ov[2]), .out_ready(out_ready)
`ifdef CROP_FILTER_UNIT_LAST_EN
    , .out_last(ol[2])
`endif
  );

  crop_filter_unit #(.PIXEL_BIT_WIDTH(PW), .IN_ROWS(4), .IN_COLS(4), .OUT_ROWS(1),
                     .OUT_COLS(1), .Y_1(3), .X_1(3)) u_one (
    .clk(clk), .reset(reset), .pixel_in(pixel_in), .in_valid(in_valid), .in_ready(ir[3]),
    .pixel_out(po[3]), .out_valid(ov[3]), .out_ready(out_ready)
`ifdef CROP_FILTER_UNIT_LAST_EN
    , .out_last(ol[3])
`endif
  );

  always_comb begin
    dut_in_ready  = ir[sel];
    dut_out_valid = ov[sel];
    dut_pixel_out = po[sel];
`ifdef CROP_FILTER_UNIT_LAST_EN
    dut_out_last  = ol[sel];
`else
    dut_out_last  = 1'b0;
`endif
  end

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Scoreboard: expected words pushed on accepted input, popped on accepted output
  always @(negedge clk) begin
    int r, c, e, last_val;
    if (!reset) begin
      exp_q.delete();
      out_log.delete();
      model_idx = 0;
      hold = 0;
    end else begin
      if (hold) begin
        check("hold_out_valid", int'(dut_out_valid), 1);
        check("hold_pixel_out", int'(dut_pixel_out), hold_pix);
      end
      hold     = dut_out_valid && !out_ready;
      hold_pix = int'(dut_pixel_out);
      if (dut_out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %0d, expected no output", dut_pixel_out);
        end else begin
          e = exp_q.pop_front();
          check("pixel_out", int'(dut_pixel_out), e);
`ifdef CROP_FILTER_UNIT_LAST_EN
          last_val = (cfg[sel].y1 + cfg[sel].out_rows - 1) * cfg[sel].in_cols +
                     cfg[sel].x1 + cfg[sel].out_cols - 1;
          check("out_last", int'(dut_out_last), (e == last_val) ? 1 : 0);
`endif
        end
        out_log.push_back(int'(dut_pixel_out));
      end
      if (in_valid && dut_in_ready) begin
        r = model_idx / cfg[sel].in_cols;
        c = model_idx % cfg[sel].in_cols;
        if (r >= cfg[sel].y1 && r < cfg[sel].y1 + cfg[sel].out_rows &&
            c >= cfg[sel].x1 && c < cfg[sel].x1 + cfg[sel].out_cols)
          exp_q.push_back(model_idx);
        model_idx = (model_idx + 1) % (cfg[sel].in_rows * cfg[sel].in_cols);
      end
    end
  end

  task automatic do_reset();
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    pixel_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", int'(dut_out_valid), 0);
    check("reset_pixel_out", int'(dut_pixel_out), 0);
    reset = 1'b1;
    #1;
    check("reset_in_ready", int'(dut_in_ready), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_pixels(input int total, input int vpct, input int rpct);
    int sent = 0;
    int cyc  = 0;
    int fsz  = cfg[sel].in_rows * cfg[sel].in_cols;
    bit acc;
    while (sent < total && cyc < total * 40 + 1000) begin
      in_valid  = ($urandom_range(0, 99) < vpct);
      out_ready = ($urandom_range(0, 99) < rpct);
      pixel_in  = PW'(sent % fsz);
      @(negedge clk);
      acc = in_valid && dut_in_ready;
      @(posedge clk);
      #1;
      if (acc) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    check("pixels_sent", sent, total);
  endtask

  task automatic drain();
    int cyc = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() > 0 || dut_out_valid) && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic check_log(input string name, input int cnt, input int first, input int last);
    check({name, "_count"}, out_log.size(), cnt);
    if (out_log.size() > 0) begin
      check({name, "_first"}, out_log[0], first);
      check({name, "_last"}, out_log[out_log.size() - 1], last);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    cfg[0] = '{100, 160, 48, 48, 10, 10};
    cfg[1] = '{8, 12, 3, 5, 2, 6};
    cfg[2] = '{4, 4, 4, 4, 0, 0};
    cfg[3] = '{4, 4, 1, 1, 3, 3};

    tbl[0] = '{"dflt_full",  0, 16000,   100, 100, 2304, 1610, 9177};
    tbl[1] = '{"small_rand", 1, 96 * 30,  50,  50,  450,   30,   58};
    tbl[2] = '{"small_full", 1, 96 * 5,  100, 100,   75,   30,   58};
    tbl[3] = '{"win_4x4",    2, 32,      100, 100,   32,    0,   15};
    tbl[4] = '{"win_1x1",    3, 48,       50,  50,    3,   15,   15};

    idx_tbl[0] = '{0, 1610};
    idx_tbl[1] = '{1, 1611};
    idx_tbl[2] = '{47, 1657};
    idx_tbl[3] = '{48, 1770};
    idx_tbl[4] = '{2303, 9177};

    sel = 2'd0;
    for (int i = 0; i < 5; i++) begin
      sel = 2'(tbl[i].sel);
      do_reset();
      send_pixels(tbl[i].pixels, tbl[i].vpct, tbl[i].rpct);
      drain();
      check_log(tbl[i].name, tbl[i].exp_count, tbl[i].exp_first, tbl[i].exp_last);
      if (i == 0) begin
        for (int j = 0; j < 5; j++) begin
          if (out_log.size() > idx_tbl[j].k)
            check($sformatf("dflt_out_%0d", idx_tbl[j].k), out_log[idx_tbl[j].k], idx_tbl[j].v);
          else
            check($sformatf("dflt_out_%0d_present", idx_tbl[j].k), out_log.size(), idx_tbl[j].k + 1);
        end
      end
    end

    // Mid-frame reset: pending output must vanish at once, next frame restarts at row 0, col 0
    sel = 2'd0;
    do_reset();
    send_pixels(5000, 100, 100);
    check("midreset_pending_valid", int'(dut_out_valid), 1);
    #2;
    reset = 1'b0;
    #1;
    check("midreset_async_valid", int'(dut_out_valid), 0);
    check("midreset_async_pixel", int'(dut_pixel_out), 0);
    #10;
    reset = 1'b1;
    @(posedge clk);
    #1;
    send_pixels(16000, 100, 100);
    drain();
    check_log("after_reset", 2304, 1610, 9177);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/crop_filter_unit.md
Name: crop_filter_unit

Overview:
- Streaming region-of-interest cropper.
- Accepts one full frame of IN_ROWS x IN_COLS pixels in raster order over a valid/ready stream.
- Forwards only the OUT_ROWS x OUT_COLS window whose top-left corner is (Y_1, X_1), unchanged and in raster order; discards every other pixel.
- Sits between a pixel source and a downstream filter (e.g. Gaussian) in the image pipeline.

Parameters:
- PIXEL_BIT_WIDTH, 16, pixel word width; passed through unmodified.
- IN_ROWS, 100, input frame height.
- IN_COLS, 160, input frame width.
- OUT_ROWS, 48, crop window height.
- OUT_COLS, 48, crop window width.
- Y_1, 10, first row of the crop window (0-based).
- X_1, 10, first column of the crop window (0-based).

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- reset  input  1  asynchronous, active-low reset.
- pixel_in  input  PIXEL_BIT_WIDTH  input pixel.
- in_valid  input  1  pixel_in is valid.
- in_ready  output  1  block can accept pixel_in this cycle.
- pixel_out  output  PIXEL_BIT_WIDTH  cropped pixel.
- out_valid  output  1  pixel_out is valid.
- out_ready  input  1  downstream accepts pixel_out this cycle.

Behaviour:
- Reset (reset low, asynchronous): row and column counters = 0, out_valid = 0, pixel_out = 0. After release, in_ready = 1.
- Input handshake: a pixel is consumed on a rising edge with in_valid & in_ready.
- in_ready = ~out_valid | out_ready, combinational. It is applied uniformly to in-window and out-of-window pixels, so discard order cannot overtake pending output.
- Counters:
  - col advances on each consumed pixel; at IN_COLS-1 it wraps to 0 and row increments.
  - At row IN_ROWS-1, col IN_COLS-1, both wrap to 0; the next frame starts with no idle cycle.
- In-window test for a consumed pixel: Y_1 <= row < Y_1+OUT_ROWS and X_1 <= col < X_1+OUT_COLS.
- Output register, one stage:
  - In-window consumed pixel: loaded into pixel_out and out_valid = 1 on the same edge. Latency is 1 cycle from the accepting edge.
  - Out-of-window consumed pixel: dropped. pixel_out is untouched, and out_valid is cleared if the held word was accepted in that cycle.
  - Output accepted (out_valid & out_ready) with no new in-window load: out_valid -> 0.
  - Accept and new in-window load on the same edge: out_valid stays 1 and pixel_out takes the new value.
  - out_valid & ~out_ready: pixel_out and out_valid are held stable, in_ready = 0.
- Data are not altered: no arithmetic, no width change.
- Throughput: 1 pixel/cycle when in_valid and out_ready are both continuously high.
- Per frame: exactly OUT_ROWS*OUT_COLS outputs.
- Reset mid-frame: counters and any pending output are discarded immediately, and the next accepted pixel is treated as row 0, col 0.
- Parameter legality, checked by an elaboration-time assertion:
  - Y_1+OUT_ROWS <= IN_ROWS.
  - X_1+OUT_COLS <= IN_COLS.
  - All sizes >= 1.
- Counter widths: $clog2 of IN_ROWS and IN_COLS, with a minimum of 1 bit.

Optional Feature:
- Macro: CROP_FILTER_UNIT_LAST_EN.
- When defined:
  - Adds output port out_last (1 bit), registered alongside pixel_out.
  - out_last = 1 with the pixel at row Y_1+OUT_ROWS-1, col X_1+OUT_COLS-1 (final cropped pixel of the frame), else 0.
  - Reset value 0; held stable under back-pressure like pixel_out.
- When undefined: the port and its logic do not exist; all other behaviour is identical.

Test Plan:
- Frame of 16000 pixels with value = raster index, in_valid = out_ready = 1 constantly, defaults -> exactly 2304 outputs. First output = 1610, next = 1611, the 48th = 1657, the 49th = 1770, last = 9177.
- Same frame with in_valid and out_ready randomized 50% each cycle -> output sequence identical to the previous case. pixel_out and out_valid never change while out_valid & ~out_ready; no duplicates, no drops.
- 100 back-to-back frames without reset -> each frame yields the same 2304-value sequence and the counters wrap cleanly. Frame 2's first output is its pixel at index 1610.
- Assert reset low after 5000 consumed pixels, then release and send a fresh frame -> out_valid drops immediately, and the next outputs begin at value 1610 of the new frame.
- Corner window: Y_1 = 0, X_1 = 0, OUT = IN = 4x4 -> all 16 pixels pass in order. Then Y_1 = 3, X_1 = 3, OUT = 1x1 -> only index 15 is output.
- With CROP_FILTER_UNIT_LAST_EN defined -> out_last is high only alongside value 9177 under default parameters.
